// File: rtl/bus_burst_master.sv
// Bus initiator that copies up to BUF_DEPTH words with a read burst into a local buffer,
// followed by a write burst from that buffer to the destination region.
`ifndef BUS_ADDR_BITS
`define BUS_ADDR_BITS 16
`endif
`ifndef BUS_DATA_BITS
`define BUS_DATA_BITS 32
`endif
`ifndef BUS_LEN_BITS
`define BUS_LEN_BITS 8
`endif

module bus_burst_master #(
  parameter int unsigned BUF_DEPTH = 16,
  parameter int unsigned LEN_BITS  = $clog2(BUF_DEPTH) + 1
) (
  input  logic                      bus_clk,
  input  logic                      bus_rst,
  input  logic                      start,
  input  logic [`BUS_ADDR_BITS-1:0] src_addr,
  input  logic [`BUS_ADDR_BITS-1:0] dst_addr,
  input  logic [LEN_BITS-1:0]       len,
  output logic                      busy,
  output logic                      done,
  output logic [`BUS_ADDR_BITS-1:0] ADDR_M,
  output logic [`BUS_DATA_BITS-1:0] WDATA_M,
  output logic [`BUS_LEN_BITS-1:0]  BLEN_M,
  output logic                      WLAST_M,
  output logic                      WVALID_M,
  output logic                      RVALID_M,
  input  logic [`BUS_DATA_BITS-1:0] RDATA_M,
  input  logic                      RLAST_M,
  input  logic                      WREADY_M,
  input  logic                      RREADY_M
);

  localparam int unsigned IdxBits = $clog2(BUF_DEPTH);
  localparam int unsigned AW      = `BUS_ADDR_BITS;
  localparam int unsigned DW      = `BUS_DATA_BITS;
  localparam int unsigned BW      = `BUS_LEN_BITS;

  typedef enum logic [2:0] {StIdle, StRd, StRdTail, StWr, StDone} state_e;

  state_e              state;
  logic [AW-1:0]       dst_q;
  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS-1:0] rd_cnt;
  logic [LEN_BITS-1:0] wr_cnt;
  logic                cap_vld;
  logic [IdxBits-1:0]  cap_idx;
  logic [DW-1:0]       buffer [BUF_DEPTH];

  logic [LEN_BITS-1:0] len_clamp;
  logic                rd_last;
  logic                wr_next_last;
  logic [IdxBits-1:0]  fwd_idx;
  logic [DW-1:0]       wdata_nxt;
  logic                unused_rlast;

  // Beats are counted locally, so the slave's last flag carries no information.
  assign unused_rlast = RLAST_M;

  assign len_clamp    = (len > LEN_BITS'(BUF_DEPTH)) ? LEN_BITS'(BUF_DEPTH) : len;
  assign rd_last      = (rd_cnt == len_q - LEN_BITS'(1));
  assign wr_next_last = ((wr_cnt + LEN_BITS'(2)) == len_q);

  // Word for the next write beat; forwards the word being captured this cycle so a
  // one-word copy does not read a stale buffer entry on entry to WR.
  always_comb begin
    fwd_idx = '0;
    if (state == StWr) begin
      fwd_idx = wr_cnt[IdxBits-1:0] + IdxBits'(1);
    end
    if (cap_vld && (cap_idx == fwd_idx)) begin
      wdata_nxt = RDATA_M;
    end else begin
      wdata_nxt = buffer[fwd_idx];
    end
  end

  always_ff @(posedge bus_clk) begin
    if (cap_vld) begin
      buffer[cap_idx] <= RDATA_M;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!bus_rst) begin
      state    <= StIdle;
      dst_q    <= '0;
      len_q    <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      cap_vld  <= 1'b0;
      cap_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ADDR_M   <= '0;
      WDATA_M  <= '0;
      BLEN_M   <= '0;
      WLAST_M  <= 1'b0;
      WVALID_M <= 1'b0;
      RVALID_M <= 1'b0;
    end else begin
      done    <= 1'b0;
      cap_vld <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            dst_q  <= dst_addr;
            len_q  <= len_clamp;
            rd_cnt <= '0;
            wr_cnt <= '0;
            busy   <= 1'b1;
            if (len_clamp == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state    <= StRd;
              RVALID_M <= 1'b1;
              ADDR_M   <= src_addr;
              BLEN_M   <= BW'(len_clamp);
            end
          end
        end
        StRd: begin
          if (RREADY_M) begin
            cap_vld <= 1'b1;
            cap_idx <= rd_cnt[IdxBits-1:0];
            rd_cnt  <= rd_cnt + LEN_BITS'(1);
            if (rd_last) begin
              state    <= StRdTail;
              RVALID_M <= 1'b0;
              ADDR_M   <= '0;
            end else begin
              ADDR_M <= ADDR_M + AW'(1);
            end
          end
        end
        StRdTail: begin
          state    <= StWr;
          WVALID_M <= 1'b1;
          ADDR_M   <= dst_q;
          WDATA_M  <= wdata_nxt;
          WLAST_M  <= (len_q == LEN_BITS'(1));
        end
        StWr: begin
          if (WREADY_M) begin
            wr_cnt <= wr_cnt + LEN_BITS'(1);
            if (WLAST_M) begin
              state    <= StDone;
              done     <= 1'b1;
              WVALID_M <= 1'b0;
              WLAST_M  <= 1'b0;
              ADDR_M   <= '0;
              WDATA_M  <= '0;
              BLEN_M   <= '0;
            end else begin
              ADDR_M  <= ADDR_M + AW'(1);
              WDATA_M <= wdata_nxt;
              WLAST_M <= wr_next_last;
            end
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_burst_master.sv
// Directed bench for bus_burst_master: a zero/programmable-wait slave model feeds read data
// and logs every accepted beat; each test task compares the log to hand-derived values.
`ifndef BUS_ADDR_BITS
`define BUS_ADDR_BITS 16
`endif
`ifndef BUS_DATA_BITS
`define BUS_DATA_BITS 32
`endif
`ifndef BUS_LEN_BITS
`define BUS_LEN_BITS 8
`endif

module tb_bus_burst_master;

  logic        bus_clk = 1'b0;
  logic        bus_rst;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [4:0]  len;
  logic        busy;
  logic        done;
  logic [15:0] ADDR_M;
  logic [31:0] WDATA_M;
  logic [7:0]  BLEN_M;
  logic        WLAST_M;
  logic        WVALID_M;
  logic        RVALID_M;
  logic [31:0] RDATA_M;
  logic        RLAST_M;
  logic        WREADY_M;
  logic        RREADY_M;

  bus_burst_master #(.BUF_DEPTH(16)) dut (
    .bus_clk  (bus_clk),
    .bus_rst  (bus_rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .ADDR_M   (ADDR_M),
    .WDATA_M  (WDATA_M),
    .BLEN_M   (BLEN_M),
    .WLAST_M  (WLAST_M),
    .WVALID_M (WVALID_M),
    .RVALID_M (RVALID_M),
    .RDATA_M  (RDATA_M),
    .RLAST_M  (RLAST_M),
    .WREADY_M (WREADY_M),
    .RREADY_M (RREADY_M)
  );

  always #5 bus_clk = ~bus_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:65535];

  // Per-command log filled by run_copy.
  logic [15:0] rd_addr [32];
  logic [15:0] wr_addr [32];
  logic [31:0] wr_data [32];
  logic        wr_last [32];
  int n_rd, n_wr, rv_cyc, wv_cyc, r_stalls, w_stalls;
  int blen_bad, both_hi, hold_bad, done_cyc;

  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [4:0] l,
                          input logic [7:0] eblen, input bit rstall, input int wst_start,
                          input int wst_len, input int pulse_cyc);
    logic        pend;
    logic [15:0] pend_addr;
    logic        prv_rs, prv_ws, prv_wlast;
    logic [15:0] prv_addr;
    logic [31:0] prv_wdata;
    n_rd = 0; n_wr = 0; rv_cyc = 0; wv_cyc = 0; r_stalls = 0; w_stalls = 0;
    blen_bad = 0; both_hi = 0; hold_bad = 0; done_cyc = -1;
    pend = 1'b0; pend_addr = '0;
    prv_rs = 1'b0; prv_ws = 1'b0; prv_wlast = 1'b0; prv_addr = '0; prv_wdata = '0;
    @(negedge bus_clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    RREADY_M = 1'b1; WREADY_M = 1'b1; RDATA_M = '0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge bus_clk);
      start = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) begin
        src_addr = 16'h0200; dst_addr = 16'h0500; len = 5'd2;
      end
      RDATA_M = pend ? mem[pend_addr] : 32'h0;
      pend = 1'b0;
      RREADY_M = rstall ? (cyc % 2 == 1) : 1'b1;
      WREADY_M = !((cyc >= wst_start) && (cyc < wst_start + wst_len));
      if (RVALID_M && WVALID_M) both_hi++;
      if ((RVALID_M || WVALID_M) && (BLEN_M !== eblen)) blen_bad++;
      if (prv_rs && (!RVALID_M || ADDR_M !== prv_addr)) hold_bad++;
      if (prv_ws && (!WVALID_M || ADDR_M !== prv_addr || WDATA_M !== prv_wdata ||
                     WLAST_M !== prv_wlast)) hold_bad++;
      if (RVALID_M) begin
        rv_cyc++;
        if (RREADY_M) begin
          pend = 1'b1; pend_addr = ADDR_M;
          if (n_rd < 32) rd_addr[n_rd] = ADDR_M;
          n_rd++;
        end else begin
          r_stalls++;
        end
      end
      if (WVALID_M) begin
        wv_cyc++;
        if (WREADY_M) begin
          if (n_wr < 32) begin
            wr_addr[n_wr] = ADDR_M; wr_data[n_wr] = WDATA_M; wr_last[n_wr] = WLAST_M;
          end
          n_wr++;
        end else begin
          w_stalls++;
        end
      end
      prv_rs = RVALID_M && !RREADY_M;
      prv_ws = WVALID_M && !WREADY_M;
      prv_addr = ADDR_M; prv_wdata = WDATA_M; prv_wlast = WLAST_M;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    RREADY_M = 1'b1; WREADY_M = 1'b1;
  endtask

  task automatic test_reset();
    bus_rst = 1'b0;
    repeat (3) @(negedge bus_clk);
    n_checks++;
    if ({busy, done, WLAST_M, WVALID_M, RVALID_M, ADDR_M, WDATA_M, BLEN_M} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b addr=%h wdata=%h blen=%h rv=%b wv=%b, want all 0",
               busy, done, ADDR_M, WDATA_M, BLEN_M, RVALID_M, WVALID_M);
    end
    bus_rst = 1'b1;
    repeat (3) @(negedge bus_clk);
    n_checks++;
    if ({busy, done, WLAST_M, WVALID_M, RVALID_M, ADDR_M, WDATA_M, BLEN_M} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: got busy=%b done=%b addr=%h rv=%b wv=%b, want all 0",
               busy, done, ADDR_M, RVALID_M, WVALID_M);
    end
  endtask

  task automatic test_basic_copy();
    run_copy(16'h0010, 16'h0040, 5'd4, 8'd4, 1'b0, 0, 0, 0);
    n_checks++;
    if (done_cyc !== 10) begin
      n_fail++; $display("FAIL basic_done_cycle: got %0d want 10", done_cyc);
    end
    n_checks++;
    if (n_rd !== 4 || n_wr !== 4) begin
      n_fail++; $display("FAIL basic_beats: got rd=%0d wr=%0d want 4/4", n_rd, n_wr);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_addr[i] !== 16'h0010 + 16'(i) || wr_addr[i] !== 16'h0040 + 16'(i) ||
          wr_data[i] !== 32'h0000_00A0 + 32'(i) || wr_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got ra=%h wa=%h wd=%h last=%b want ra=%h wa=%h wd=%h last=%b",
                 i, rd_addr[i], wr_addr[i], wr_data[i], wr_last[i], 16'h0010 + 16'(i),
                 16'h0040 + 16'(i), 32'h0000_00A0 + 32'(i), (i == 3));
      end
    end
    n_checks++;
    if (blen_bad !== 0 || both_hi !== 0) begin
      n_fail++; $display("FAIL basic_blen_excl: got blen_bad=%0d both_hi=%0d want 0/0", blen_bad, both_hi);
    end
    @(negedge bus_clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_done: got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_backpressure();
    run_copy(16'h0010, 16'h0040, 5'd4, 8'd4, 1'b1, 10, 3, 0);
    n_checks++;
    if (r_stalls !== 3 || w_stalls !== 3) begin
      n_fail++; $display("FAIL bp_stalls: got r=%0d w=%0d want 3/3", r_stalls, w_stalls);
    end
    n_checks++;
    if (done_cyc !== 16) begin
      n_fail++; $display("FAIL bp_done_cycle: got %0d want 16", done_cyc);
    end
    n_checks++;
    if (hold_bad !== 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d violations want 0", hold_bad);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_addr[i] !== 16'h0010 + 16'(i) || wr_addr[i] !== 16'h0040 + 16'(i) ||
          wr_data[i] !== 32'h0000_00A0 + 32'(i)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got ra=%h wa=%h wd=%h want %h %h %h", i, rd_addr[i], wr_addr[i],
                 wr_data[i], 16'h0010 + 16'(i), 16'h0040 + 16'(i), 32'h0000_00A0 + 32'(i));
      end
    end
  endtask

  task automatic test_edge_commands();
    run_copy(16'h0010, 16'h0040, 5'd0, 8'd0, 1'b0, 0, 0, 0);
    n_checks++;
    if (done_cyc !== 1 || rv_cyc !== 0 || wv_cyc !== 0) begin
      n_fail++;
      $display("FAIL len0: got done_cyc=%0d rv=%0d wv=%0d want 1/0/0", done_cyc, rv_cyc, wv_cyc);
    end
    run_copy(16'h0100, 16'h0300, 5'd20, 8'd16, 1'b0, 0, 0, 0);
    n_checks++;
    if (n_rd !== 16 || n_wr !== 16 || blen_bad !== 0 || done_cyc !== 34) begin
      n_fail++;
      $display("FAIL clamp: got rd=%0d wr=%0d blen_bad=%0d done_cyc=%0d want 16/16/0/34",
               n_rd, n_wr, blen_bad, done_cyc);
    end
    n_checks++;
    if (wr_addr[15] !== 16'h030F || wr_data[15] !== 32'hD000_010F || wr_last[15] !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_last: got wa=%h wd=%h last=%b want 030f d000010f 1",
               wr_addr[15], wr_data[15], wr_last[15]);
    end
    run_copy(16'h0010, 16'h0040, 5'd4, 8'd4, 1'b0, 0, 0, 2);
    n_checks++;
    if (done_cyc !== 10 || n_rd !== 4 || rd_addr[3] !== 16'h0013 || wr_addr[0] !== 16'h0040) begin
      n_fail++;
      $display("FAIL start_ignored: got done_cyc=%0d rd=%0d ra3=%h wa0=%h want 10/4/0013/0040",
               done_cyc, n_rd, rd_addr[3], wr_addr[0]);
    end
    @(negedge bus_clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL start_ignored_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_addr_wrap();
    run_copy(16'hFFFE, 16'h0080, 5'd3, 8'd3, 1'b0, 0, 0, 0);
    n_checks++;
    if (rd_addr[0] !== 16'hFFFE || rd_addr[1] !== 16'hFFFF || rd_addr[2] !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_addr: got %h %h %h want fffe ffff 0000", rd_addr[0], rd_addr[1], rd_addr[2]);
    end
    n_checks++;
    if (wr_data[2] !== 32'hD000_0000 || wr_data[0] !== 32'hD000_FFFE || done_cyc !== 8) begin
      n_fail++;
      $display("FAIL wrap_data: got wd0=%h wd2=%h done_cyc=%0d want d000fffe d0000000 8",
               wr_data[0], wr_data[2], done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int saw_done;
    @(negedge bus_clk);
    src_addr = 16'h0010; dst_addr = 16'h0040; len = 5'd4; start = 1'b1;
    RREADY_M = 1'b1; WREADY_M = 1'b1; RDATA_M = '0;
    @(negedge bus_clk);
    start = 1'b0;
    repeat (6) @(negedge bus_clk);
    n_checks++;
    if (WVALID_M !== 1'b1 || ADDR_M !== 16'h0041) begin
      n_fail++; $display("FAIL mid_second_beat: got wv=%b addr=%h want 1 0041", WVALID_M, ADDR_M);
    end
    bus_rst = 1'b0;
    @(negedge bus_clk);
    n_checks++;
    if (WVALID_M !== 1'b0 || RVALID_M !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got wv=%b rv=%b busy=%b done=%b want 0", WVALID_M, RVALID_M, busy, done);
    end
    bus_rst = 1'b1;
    saw_done = 0;
    repeat (5) begin
      @(negedge bus_clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done++;
    end
    n_checks++;
    if (saw_done !== 0) begin
      n_fail++; $display("FAIL mid_no_done: got %0d active cycles want 0", saw_done);
    end
    run_copy(16'h0010, 16'h0040, 5'd4, 8'd4, 1'b0, 0, 0, 0);
    n_checks++;
    if (done_cyc !== 10 || n_wr !== 4 || wr_data[3] !== 32'h0000_00A3) begin
      n_fail++;
      $display("FAIL mid_fresh: got done_cyc=%0d wr=%0d wd3=%h want 10/4/000000a3",
               done_cyc, n_wr, wr_data[3]);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {16'hD000, 16'(i)};
    for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 32'h0000_00A0 + 32'(i);
    bus_rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    RDATA_M = '0; RLAST_M = 1'b0; WREADY_M = 1'b1; RREADY_M = 1'b1;
    test_reset();
    test_basic_copy();
    test_backpressure();
    test_edge_commands();
    test_addr_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
